mem_access_unit: RTL and testbench

// - MEM-stage initiator for the data-memory request/response interface; the requesting side
//   of the word/half/byte store and load path.
// - Takes one load/store op from the pipeline, checks alignment, forms byte enables and

---
 rtl/mem_access_unit_if.sv | 22 ++
 rtl/mem_access_unit.sv | 182 ++++++++++++++++++
 tb/tb_mem_access_unit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory request/response bus between the MEM-stage access unit (master)
// and the memory or interconnect (slave).
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [3:0]  req_be;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_be, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_be, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: alignment check, lane steering, bus handshake, load extension.
// Optional store trace enabled by defining MAU_TRACE_EN.
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [31:0] op_pc,
    output logic        stall,
    output logic        done,
    output logic [31:0] ld_data,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_err,
    mem_access_unit_if.master bus
);
    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [31:0]       ld_data_n;
    logic              exc_adel_n, exc_ades_n, bus_err_n;
    logic [1:0]        size;
    logic              is_store, misaligned, timeout, in_req;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;

    // Access size code: 2 = word, 1 = half, 0 = byte
    function automatic logic [1:0] size_of(input logic [2:0] t);
        case (t)
            OP_LW, OP_SW:         size_of = 2'd2;
            OP_LH, OP_LHU, OP_SH: size_of = 2'd1;
            default:              size_of = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] be_of(input logic [1:0] sz, input logic [1:0] lo);
        case (sz)
            2'd2:    be_of = 4'b1111;
            2'd1:    be_of = lo[1] ? 4'b1100 : 4'b0011;
            default: be_of = 4'b0001 << lo;
        endcase
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'd2:    replicate = d;
            2'd1:    replicate = {2{d[15:0]}};
            default: replicate = {4{d[7:0]}};
        endcase
    endfunction

    function automatic logic [31:0] extend_load(input logic [2:0] t, input logic [1:0] lo,
                                                input logic [31:0] w);
        logic signed [7:0]  b;
        logic signed [15:0] h;
        logic signed [31:0] s;
        b = w[{lo, 3'b000} +: 8];
        h = w[{lo[1], 4'b0000} +: 16];
        s = '0;
        extend_load = w;
        case (t)
            OP_LB:   begin s = b; extend_load = s; end
            OP_LH:   begin s = h; extend_load = s; end
            OP_LBU:  extend_load = {24'd0, b};
            OP_LHU:  extend_load = {16'd0, h};
            default: extend_load = w;
        endcase
    endfunction

    assign size       = size_of(op_type);
    assign is_store   = (op_type == OP_SW) || (op_type == OP_SH) || (op_type == OP_SB);
    assign misaligned = ((size == 2'd2) && (op_addr[1:0] != 2'b00)) ||
                        ((size == 2'd1) && op_addr[0]);
    assign be         = be_of(size, op_addr[1:0]);
    assign wdata_rep  = replicate(size, op_wdata);
    // A handshake in the same cycle as the limit is reached still completes the phase
    assign timeout    = (TIMEOUT_CYCLES != 0) && (cnt >= CNT_LAST);

    assign in_req        = (state == S_REQ);
    assign done          = (state == S_DONE);
    assign stall         = op_valid & ~done;
    assign bus.req_valid = in_req;
    assign bus.req_we    = in_req & is_store;
    assign bus.req_addr  = in_req ? {op_addr[31:2], 2'b00} : 32'd0;
    assign bus.req_be    = in_req ? be : 4'd0;
    assign bus.req_wdata = in_req && is_store ? wdata_rep : 32'd0;

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        ld_data_n  = 32'd0;
        exc_adel_n = 1'b0;
        exc_ades_n = 1'b0;
        bus_err_n  = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_valid) begin
                    cnt_n = '0;
                    if (misaligned) begin
                        state_n    = S_DONE;
                        exc_ades_n = is_store;
                        exc_adel_n = ~is_store;
                    end else begin
                        state_n = S_REQ;
                    end
                end
            end
            S_REQ: begin
                cnt_n = cnt + 1'b1;
                if (bus.req_ready) begin
                    state_n = is_store ? S_DONE : S_WAIT;
                end else if (timeout) begin
                    state_n   = S_DONE;
                    bus_err_n = 1'b1;
                end
            end
            S_WAIT: begin
                cnt_n = cnt + 1'b1;
                if (bus.resp_valid) begin
                    state_n   = S_DONE;
                    ld_data_n = extend_load(op_type, op_addr[1:0], bus.resp_rdata);
                end else if (timeout) begin
                    state_n   = S_DONE;
                    bus_err_n = 1'b1;
                end
            end
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Status and load result are registered on entry to DONE and cleared otherwise
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            ld_data  <= 32'd0;
            exc_adel <= 1'b0;
            exc_ades <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            ld_data  <= ld_data_n;
            exc_adel <= exc_adel_n;
            exc_ades <= exc_ades_n;
            bus_err  <= bus_err_n;
        end
    end

`ifdef MAU_TRACE_EN
    logic [31:0] merged_word;
    assign merged_word = bus.req_wdata & {{8{bus.req_be[3]}}, {8{bus.req_be[2]}},
                                          {8{bus.req_be[1]}}, {8{bus.req_be[0]}}};

    always_ff @(posedge clk) begin
        if (!reset && in_req && bus.req_ready && bus.req_we)
            $display("%d@%h: *%h <= %h", $time, op_pc, bus.req_addr, merged_word);
    end
`else
    logic unused_pc;
    assign unused_pc = ^op_pc;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed spec cases, timeouts, reset, random ops.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op_type;
    logic [31:0] op_addr, op_wdata, op_pc;
    logic        stall, done, exc_adel, exc_ades, bus_err;
    logic [31:0] ld_data;
    int          checks = 0;
    int          errors = 0;

    mem_access_unit_if bus();

    mem_access_unit dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_type(op_type),
        .op_addr(op_addr), .op_wdata(op_wdata), .op_pc(op_pc), .stall(stall),
        .done(done), .ld_data(ld_data), .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_err(bus_err), .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          lat;
        int          nreq;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] addr;
        logic        we;
        logic [31:0] ld;
        logic [2:0]  status;   // {adel, ades, berr}
        logic        rv_done;
        int          stall_err;
    } obs_t;

    // ---------------- reference model ----------------
    function automatic int unsigned m_size(input logic [2:0] t);
        case (t)
            3'd0, 3'd5:       return 4;
            3'd1, 3'd2, 3'd6: return 2;
            default:          return 1;
        endcase
    endfunction

    function automatic bit m_store(input logic [2:0] t);
        return t >= 3'd5;
    endfunction

    function automatic bit m_misal(input logic [2:0] t, input logic [31:0] a);
        return (a % m_size(t)) != 0;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] t, input logic [31:0] a);
        int unsigned n, lane, v;
        n    = m_size(t);
        lane = (a % 4) / n * n;
        v    = ((1 << n) - 1) << lane;
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] t, input logic [31:0] d);
        longint unsigned piece, r;
        int unsigned n;
        n = m_size(t);
        piece = longint'(d) % (64'd1 << (8 * n));
        r = 0;
        for (int i = 0; i < 4 / n; i++) r += piece << (8 * n * i);
        return r[31:0];
    endfunction

    function automatic logic [31:0] m_ld(input logic [2:0] t, input logic [31:0] a,
                                         input logic [31:0] rd);
        longint v;
        int unsigned n;
        n = m_size(t);
        v = (longint'(rd) >> (8 * (a % 4 / n * n))) % (longint'(1) << (8 * n));
        if ((t == 3'd1 || t == 3'd3) && v >= (longint'(1) << (8 * n - 1)))
            v -= longint'(1) << (8 * n);
        return v[31:0];
    endfunction

    // Timeout: 16 cycles in REQ+WAIT without finishing the current phase
    function automatic bit m_tmo(input logic [2:0] t, input logic [31:0] a, input int rdy, input int rsp);
        if (m_misal(t, a)) return 0;
        if (rdy + 1 > 16) return 1;
        return !m_store(t) && (rdy + rsp + 2 > 16);
    endfunction

    function automatic int m_lat(input logic [2:0] t, input logic [31:0] a, input int rdy, input int rsp);
        if (m_misal(t, a)) return 1;
        if (m_tmo(t, a, rdy, rsp)) return 17;
        if (m_store(t)) return rdy + 2;
        return rdy + rsp + 3;
    endfunction

    // ---------------- driver / memory responder ----------------
    task automatic run_op(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int rdy, input int rsp, input bit early,
                          output obs_t o);
        int nwait;
        bit acc;
        o = '{default: 0};
        nwait = 0;
        acc = 0;
        @(negedge clk);
        op_valid = 1'b1; op_type = t; op_addr = a; op_wdata = d; op_pc = $urandom;
        bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (stall !== (op_valid & ~done)) o.stall_err++;
            if (done === 1'b1) begin
                o.lat = k;
                o.ld = ld_data;
                o.status = {exc_adel, exc_ades, bus_err};
                o.rv_done = bus.req_valid;
                break;
            end
            if (bus.req_valid === 1'b1) begin
                o.nreq++;
                o.be = bus.req_be; o.wdata = bus.req_wdata; o.addr = bus.req_addr; o.we = bus.req_we;
                bus.req_ready = (o.nreq > rdy);
                acc = bus.req_ready;
                bus.resp_valid = early & bus.req_ready;
                bus.resp_rdata = ~rd;
            end else begin
                bus.req_ready = 1'b0;
                bus.resp_valid = acc && (nwait == rsp);
                bus.resp_rdata = (acc && nwait == rsp) ? rd : $urandom;
                if (acc) nwait++;
            end
        end
        op_valid = 1'b0; bus.req_ready = 1'b0; bus.resp_valid = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; op_valid = 1'b0; op_type = 3'd0; op_addr = 32'd0; op_wdata = 32'd0;
        op_pc = 32'd0; bus.req_ready = 1'b0; bus.resp_valid = 1'b0; bus.resp_rdata = 32'd0;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b want 0", bus.req_valid); end
        checks++; if ({exc_adel, exc_ades, bus_err} !== 3'b000) begin errors++; $display("FAIL reset_status: got %b want 000", {exc_adel, exc_ades, bus_err}); end
        checks++; if (ld_data !== 32'd0) begin errors++; $display("FAIL reset_ld_data: got %h want 0", ld_data); end
        checks++; if ({bus.req_we, bus.req_be, bus.req_addr, bus.req_wdata} !== 69'd0) begin errors++; $display("FAIL reset_req_payload: got %h want 0", {bus.req_we, bus.req_be, bus.req_addr, bus.req_wdata}); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall_idle: got %b want 0", stall); end
        op_valid = 1'b1; op_type = 3'd5;
        @(negedge clk);
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL reset_stall_op: got %b want 1", stall); end
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_req: got %b want 0", bus.req_valid); end
        op_valid = 1'b0; reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [2:0]  tt [11] = '{3'd5, 3'd7, 3'd6, 3'd3, 3'd4, 3'd1, 3'd2, 3'd0, 3'd6, 3'd5, 3'd0};
        logic [31:0] aa [11] = '{32'h10, 32'h13, 32'h12, 32'h01, 32'h01, 32'h02, 32'h02, 32'h06, 32'h03, 32'h11, 32'h08};
        logic [31:0] dd [11] = '{32'h12345678, 32'hAB, 32'h5A5ABEEF, 0, 0, 0, 0, 0, 32'h1234, 32'h1, 0};
        logic [31:0] rr [11] = '{0, 0, 0, 32'h000080FF, 32'h000080FF, 32'h80010000, 32'h80010000, 32'h1, 0, 0, 32'hDEADBEEF};
        obs_t o;
        for (int i = 0; i < 11; i++) begin
            bit mis, st;
            run_op(tt[i], aa[i], dd[i], rr[i], 0, 0, 1'b0, o);
            mis = m_misal(tt[i], aa[i]);
            st  = m_store(tt[i]);
            checks++; if (o.lat !== m_lat(tt[i], aa[i], 0, 0)) begin errors++; $display("FAIL dir_lat[%0d]: got %0d want %0d", i, o.lat, m_lat(tt[i], aa[i], 0, 0)); end
            checks++; if (o.status !== {mis & ~st, mis & st, 1'b0}) begin errors++; $display("FAIL dir_status[%0d]: got %b want %b", i, o.status, {mis & ~st, mis & st, 1'b0}); end
            checks++; if (o.nreq !== (mis ? 0 : 1)) begin errors++; $display("FAIL dir_nreq[%0d]: got %0d want %0d", i, o.nreq, mis ? 0 : 1); end
            if (!mis) begin
                checks++; if (o.be !== m_be(tt[i], aa[i])) begin errors++; $display("FAIL dir_be[%0d]: got %b want %b", i, o.be, m_be(tt[i], aa[i])); end
                checks++; if (o.addr !== {aa[i][31:2], 2'b00}) begin errors++; $display("FAIL dir_addr[%0d]: got %h want %h", i, o.addr, {aa[i][31:2], 2'b00}); end
            end
            if (!mis && st) begin
                checks++; if (o.wdata !== m_wdata(tt[i], dd[i])) begin errors++; $display("FAIL dir_wdata[%0d]: got %h want %h", i, o.wdata, m_wdata(tt[i], dd[i])); end
            end
            checks++; if (o.ld !== ((!mis && !st) ? m_ld(tt[i], aa[i], rr[i]) : 32'd0)) begin errors++; $display("FAIL dir_ld[%0d]: got %h want %h", i, o.ld, (!mis && !st) ? m_ld(tt[i], aa[i], rr[i]) : 32'd0); end
        end
    endtask

    task automatic test_timeout();
        logic [2:0] tt [3] = '{3'd0, 3'd5, 3'd4};
        int         rd [3] = '{0, 1000, 20};
        obs_t o;
        for (int i = 0; i < 3; i++) begin
            run_op(tt[i], 32'h40, 32'hCAFE, 32'h1234, rd[i], 1000, 1'b0, o);
            checks++; if (o.lat !== 17) begin errors++; $display("FAIL tmo_lat[%0d]: got %0d want 17", i, o.lat); end
            checks++; if (o.status !== 3'b001) begin errors++; $display("FAIL tmo_status[%0d]: got %b want 001", i, o.status); end
            checks++; if (o.ld !== 32'd0) begin errors++; $display("FAIL tmo_ld[%0d]: got %h want 0", i, o.ld); end
            checks++; if (o.rv_done !== 1'b0) begin errors++; $display("FAIL tmo_req_drop[%0d]: got %b want 0", i, o.rv_done); end
            checks++; if (o.nreq !== (rd[i] == 0 ? 1 : 16)) begin errors++; $display("FAIL tmo_nreq[%0d]: got %0d want %0d", i, o.nreq, rd[i] == 0 ? 1 : 16); end
        end
    endtask

    task automatic test_reset_mid_op();
        obs_t o;
        @(negedge clk);
        op_valid = 1'b1; op_type = 3'd0; op_addr = 32'h20; bus.req_ready = 1'b1;
        @(negedge clk);
        bus.req_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1; bus.resp_valid = 1'b1; bus.resp_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        checks++; if (bus.req_valid !== 1'b0) begin errors++; $display("FAIL rstmid_req_valid: got %b want 0", bus.req_valid); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_stall: got %b want 1", stall); end
        reset = 1'b0; op_valid = 1'b0;
        @(negedge clk);
        checks++; if ({done, bus.req_valid, ld_data} !== 34'd0) begin errors++; $display("FAIL rstmid_discard: got %h want 0", {done, bus.req_valid, ld_data}); end
        bus.resp_valid = 1'b0;
        run_op(3'd1, 32'h22, 32'd0, 32'h7FFF0000, 0, 0, 1'b0, o);
        checks++; if (o.lat !== 3) begin errors++; $display("FAIL rstmid_next_lat: got %0d want 3", o.lat); end
        checks++; if (o.ld !== 32'h00007FFF) begin errors++; $display("FAIL rstmid_next_ld: got %h want 00007fff", o.ld); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        for (int i = 0; i < 4; i++) begin
            logic [2:0] t;
            t = (i % 2 == 0) ? 3'd5 : 3'd4;
            run_op(t, 32'h100 + 32'(i), 32'h11223344 + 32'(i), 32'hF1F2F3F4, 0, 0, 1'b1, o);
            checks++; if (o.lat !== m_lat(t, 32'h100 + 32'(i), 0, 0)) begin errors++; $display("FAIL b2b_lat[%0d]: got %0d want %0d", i, o.lat, m_lat(t, 32'h100 + 32'(i), 0, 0)); end
            checks++; if (o.stall_err !== 0) begin errors++; $display("FAIL b2b_stall[%0d]: got %0d bad cycles want 0", i, o.stall_err); end
        end
    endtask

    task automatic test_random();
        obs_t o;
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  t;
            logic [31:0] a, d, rd;
            int          rdy, rsp;
            bit          mis, st, early;
            logic [31:0] eld;
            t = 3'($urandom_range(0, 7));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~(m_size(t) - 1);
            d = $urandom; rd = $urandom;
            rdy = $urandom_range(0, 4); rsp = $urandom_range(0, 4); early = 1'($urandom_range(0, 1));
            run_op(t, a, d, rd, rdy, rsp, early, o);
            mis = m_misal(t, a);
            st  = m_store(t);
            eld = (!mis && !st) ? m_ld(t, a, rd) : 32'd0;
            checks++; if (o.lat !== m_lat(t, a, rdy, rsp)) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, o.lat, m_lat(t, a, rdy, rsp)); end
            checks++; if (o.status !== {mis & ~st, mis & st, 1'b0}) begin errors++; $display("FAIL rnd_status[%0d]: got %b want %b", i, o.status, {mis & ~st, mis & st, 1'b0}); end
            checks++; if (o.ld !== eld) begin errors++; $display("FAIL rnd_ld[%0d]: got %h want %h", i, o.ld, eld); end
            checks++; if (o.nreq !== (mis ? 0 : rdy + 1)) begin errors++; $display("FAIL rnd_nreq[%0d]: got %0d want %0d", i, o.nreq, mis ? 0 : rdy + 1); end
            checks++; if (o.stall_err !== 0) begin errors++; $display("FAIL rnd_stall[%0d]: got %0d bad cycles want 0", i, o.stall_err); end
            if (!mis) begin
                checks++; if ({o.we, o.be} !== {st, m_be(t, a)}) begin errors++; $display("FAIL rnd_we_be[%0d]: got %b want %b", i, {o.we, o.be}, {st, m_be(t, a)}); end
                checks++; if (o.addr !== {a[31:2], 2'b00}) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, o.addr, {a[31:2], 2'b00}); end
                if (st) begin
                    checks++; if (o.wdata !== m_wdata(t, d)) begin errors++; $display("FAIL rnd_wdata[%0d]: got %h want %h", i, o.wdata, m_wdata(t, d)); end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_timeout();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end
endmodule
